bp_be_clint_responder: RTL and testbench
========================================

Name: bp_be_clint_responder

Overview:
MMIO responder for the machine-timer and software-interrupt region: services loads and stores to mtime, per-hart mtimecmp and per-hart msoftint. Owns the free-running mtime counter and drives per-hart timer and software interrupt lines into each core's CSR/interrupt logic. Sits behind the MMIO router on the uncached path; one request outstanding at a time.

Parameters:
num_core_p, 8, harts served (1..8); harts >= num_core_p are unmapped
paddr_width_p, 39, physical address width
dword_width_p, 64, data width
timer_div_p, 1, core clocks per mtime increment (>= 1)

Ports:
clk_i  in  1  core clock
reset_i  in  1  asynchronous, active-high reset
req_v_i  in  1  request valid
req_ready_o  out  1  request ready
req_addr_i  in  paddr_width_p  physical address
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  log2 bytes; only 2'b11 (dword) legal
req_data_i  in  dword_width_p  store data
resp_v_o  out  1  response valid
resp_ready_i  in  1  response ready
resp_data_o  out  dword_width_p  load data; 0 for stores and errors
resp_err_o  out  1  access error
timer_irq_o  out  num_core_p  per-hart machine timer interrupt
soft_irq_o  out  num_core_p  per-hart machine software interrupt

Behaviour:
- Reset (async, active-high), all state cleared immediately: mtime=0, prescaler=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, every msoftint=0, FSM=IDLE, resp_v_o=0, resp_data_o=0, resp_err_o=0, timer_irq_o=0, soft_irq_o=0. Reset mid-transaction drops the in-flight request; no response is issued.
- Address map: mtime 39'h6f_ffff_0000; mtimecmp[h] 39'h6f_ffff_0100+8h; msoftint[h] 39'h6f_ffff_0200+8h, h<num_core_p. Anything else is unmapped.
- Error conditions: unmapped address, addr[2:0]!=0, or req_size_i!=2'b11. Response has resp_err_o=1 and resp_data_o=0. No state changes.
- FSM has two states. IDLE: req_ready_o=1. On req_v_i&req_ready_o, decode, perform the write or capture read data, go to RESP. RESP: req_ready_o=0, resp_v_o=1. Response fields stay stable until resp_ready_i. On resp_v_o&resp_ready_i, go to IDLE.
- Latency: the response is valid exactly 1 cycle after acceptance. Back-to-back throughput is one request per 2 cycles.
- Read data is sampled at the acceptance edge. An mtime read returns the value before that cycle's increment.
- msoftint: only bit 0 is stored; a read returns {63'b0, bit}.
- mtime: prescaler counts 0..timer_div_p-1. mtime increments by 1 when the prescaler is at timer_div_p-1, and the prescaler then wraps to 0. mtime wraps 2^64-1 -> 0.
- A store to mtime in the same cycle as an increment: the store wins, and mtime takes req_data_i exactly. The prescaler is unaffected.
- Interrupts are registered:
  - timer_irq_o[h] <= (mtime >= mtimecmp[h]), unsigned compare on current register values, so it is 1 cycle behind any mtime/mtimecmp update.
  - soft_irq_o[h] <= msoftint[h].
  - The level stays asserted until software raises mtimecmp or clears msoftint.
- The counter keeps running regardless of FSM state or response backpressure.

Decomposition:
- bp_be_pkg gains:
  - bp_be_clint_req_s {addr, we, size, data} and bp_be_clint_resp_s {data, err} typedefs.
  - A two-state FSM enum.
  - Region offset constants: mtime 16'h0000, mtimecmp 16'h0100, msoftint 16'h0200, and hart stride 8.
- The existing address localparams remain the single source of absolute addresses.
- Sub-module bp_be_clint_decode: combinational address/size decode producing {is_mtime, is_mtimecmp, is_msoftint, hart_idx, err}. Register file, counter, FSM and compare stay in the top.

Test Plan:
- Reset, then idle 10 cycles with timer_div_p=1 -> load mtime returns 10 (+/- handshake offset checked exactly by model); all irq outputs 0.
- Store mtimecmp[2]=20 -> timer_irq_o[2] rises on the cycle after mtime reaches 20. Store mtimecmp[2]=64'hFFFF... -> the line drops 1 cycle after the write. Other harts stay 0.
- Store msoftint[5]=64'hFFFF_FFFF_FFFF_FFFF -> soft_irq_o[5]=1 next cycle, and a load returns 1. Store 0 -> soft_irq_o[5]=0.
- Load 39'h6f_ffff_0300, load 39'h6f_ffff_0104 (misaligned), and store with size 2'b10 -> each returns resp_err_o=1, data 0, no state change. With num_core_p=4, mtimecmp[6] -> error.
- Hold resp_ready_i=0 for 5 cycles after a load -> resp_v_o and resp_data_o stable, req_ready_o=0, mtime keeps counting. Release -> next request accepted the cycle after.
- Store mtime=64'hFFFF_FFFF_FFFF_FFFE with timer_div_p=3 -> mtime wraps to 0 after 6 cycles. Assert reset mid-RESP -> resp_v_o drops immediately, and all reset values hold.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared back-end types and constants used by the CLINT MMIO responder.
// Absolute addresses here are the only place the CLINT region location is spelled out.
package bp_be_pkg;

  localparam int unsigned clint_paddr_width_gp    = 39;
  localparam int unsigned clint_dword_width_gp    = 64;
  localparam int unsigned clint_max_harts_gp      = 8;
  localparam int unsigned clint_hart_idx_width_gp = 3;
  localparam int unsigned clint_hart_stride_gp    = 8;
  localparam int unsigned clint_hart_stride_lg_gp = $clog2(clint_hart_stride_gp);
  localparam int unsigned clint_slot_width_gp     = 16 - clint_hart_stride_lg_gp;

  localparam logic [clint_paddr_width_gp-1:0] clint_mtime_addr_gp    = 39'h6f_ffff_0000;
  localparam logic [clint_paddr_width_gp-1:0] clint_mtimecmp_addr_gp = 39'h6f_ffff_0100;
  localparam logic [clint_paddr_width_gp-1:0] clint_msoftint_addr_gp = 39'h6f_ffff_0200;

  localparam logic [15:0] clint_mtime_offset_gp    = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h0100;
  localparam logic [15:0] clint_msoftint_offset_gp = 16'h0200;

  typedef enum logic {
    e_clint_idle,
    e_clint_resp
  } bp_be_clint_state_e;

  typedef struct packed {
    logic [clint_paddr_width_gp-1:0] addr;
    logic                            we;
    logic [1:0]                      size;
    logic [clint_dword_width_gp-1:0] data;
  } bp_be_clint_req_s;

  typedef struct packed {
    logic [clint_dword_width_gp-1:0] data;
    logic                            err;
  } bp_be_clint_resp_s;

  // Dword slot index of a 16-bit region offset (one slot per hart stride).
  function automatic logic [clint_slot_width_gp-1:0] clint_offset_slot(input logic [15:0] offset);
    return clint_slot_width_gp'(offset >> clint_hart_stride_lg_gp);
  endfunction

endpackage

// File: rtl/bp_be_clint_decode.sv
// Combinational decode of a CLINT request address/size into a target register and hart.
// Target flags are only raised for legal accesses; err covers unmapped, misaligned and non-dword.
module bp_be_clint_decode
  import bp_be_pkg::*;
#(
  parameter int unsigned num_core_p    = 8,
  parameter int unsigned paddr_width_p = clint_paddr_width_gp
) (
  input  logic [paddr_width_p-1:0]           addr,
  input  logic [1:0]                         size,
  output logic                               is_mtime,
  output logic                               is_mtimecmp,
  output logic                               is_msoftint,
  output logic [clint_hart_idx_width_gp-1:0] hart_idx,
  output logic                               err
);

  localparam logic [paddr_width_p-1:0] region_base_lp =
    paddr_width_p'(clint_mtime_addr_gp) - paddr_width_p'(clint_mtime_offset_gp);

  logic                           region_hit;
  logic [clint_slot_width_gp-1:0] slot;
  logic [clint_slot_width_gp-1:0] cmp_idx;
  logic [clint_slot_width_gp-1:0] soft_idx;
  logic                           mtime_hit;
  logic                           cmp_hit;
  logic                           soft_hit;

  // Offsets below a region base wrap to large indices and fall out of the hart range.
  always_comb begin
    region_hit = (addr[paddr_width_p-1:16] == region_base_lp[paddr_width_p-1:16]);
    slot       = clint_offset_slot(addr[15:0]);
    cmp_idx    = slot - clint_offset_slot(clint_mtimecmp_offset_gp);
    soft_idx   = slot - clint_offset_slot(clint_msoftint_offset_gp);

    mtime_hit  = region_hit & (slot == clint_offset_slot(clint_mtime_offset_gp));
    cmp_hit    = region_hit & (cmp_idx  < clint_slot_width_gp'(num_core_p));
    soft_hit   = region_hit & (soft_idx < clint_slot_width_gp'(num_core_p));

    err = ~(mtime_hit | cmp_hit | soft_hit)
        | (addr[2:0] != 3'b000)
        | (size != 2'b11);

    is_mtime    = mtime_hit & ~err;
    is_mtimecmp = cmp_hit   & ~err;
    is_msoftint = soft_hit  & ~err;
    hart_idx    = cmp_hit ? cmp_idx[clint_hart_idx_width_gp-1:0]
                          : soft_idx[clint_hart_idx_width_gp-1:0];
  end

endmodule

// File: rtl/bp_be_clint_responder.sv
// MMIO responder for mtime, per-hart mtimecmp and msoftint; owns the mtime counter
// and drives registered per-hart timer and software interrupt levels.
module bp_be_clint_responder
  import bp_be_pkg::*;
#(
  parameter int unsigned num_core_p    = 8,
  parameter int unsigned paddr_width_p = 39,
  parameter int unsigned dword_width_p = 64,
  parameter int unsigned timer_div_p   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic [dword_width_p-1:0] req_data_i,

  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [dword_width_p-1:0] resp_data_o,
  output logic                     resp_err_o,

  output logic [num_core_p-1:0]    timer_irq_o,
  output logic [num_core_p-1:0]    soft_irq_o
);

  localparam int unsigned presc_width_lp = (timer_div_p > 1) ? $clog2(timer_div_p) : 1;
  localparam logic [presc_width_lp-1:0] presc_max_lp = presc_width_lp'(timer_div_p - 1);

  bp_be_clint_req_s                     req;
  bp_be_clint_resp_s                    resp_r;
  bp_be_clint_state_e                   state_r;

  logic [clint_dword_width_gp-1:0]      mtime_r;
  logic [presc_width_lp-1:0]            presc_r;
  logic [clint_dword_width_gp-1:0]      mtimecmp_r [num_core_p];
  logic [num_core_p-1:0]                msoftint_r;
  logic [num_core_p-1:0]                timer_irq_r;
  logic [num_core_p-1:0]                soft_irq_r;

  logic                                 is_mtime;
  logic                                 is_mtimecmp;
  logic                                 is_msoftint;
  logic [clint_hart_idx_width_gp-1:0]   hart_idx;
  logic                                 dec_err;

  logic                                 accept;
  logic                                 tick;
  logic                                 wr_mtime;
  logic [clint_dword_width_gp-1:0]      rdata;

  assign req = '{addr: clint_paddr_width_gp'(req_addr_i),
                 we:   req_we_i,
                 size: req_size_i,
                 data: clint_dword_width_gp'(req_data_i)};

  bp_be_clint_decode #(
    .num_core_p    (num_core_p),
    .paddr_width_p (clint_paddr_width_gp)
  ) decode (
    .addr        (req.addr),
    .size        (req.size),
    .is_mtime    (is_mtime),
    .is_mtimecmp (is_mtimecmp),
    .is_msoftint (is_msoftint),
    .hart_idx    (hart_idx),
    .err         (dec_err)
  );

  assign accept   = req_v_i & (state_r == e_clint_idle);
  assign tick     = (presc_r == presc_max_lp);
  assign wr_mtime = accept & req.we & is_mtime;

  // Read mux over current register values, i.e. before this edge's updates.
  always_comb begin
    rdata = '0;
    if (is_mtime) rdata = mtime_r;
    for (int h = 0; h < num_core_p; h++) begin
      if (is_mtimecmp && (hart_idx == clint_hart_idx_width_gp'(h))) rdata = mtimecmp_r[h];
      if (is_msoftint && (hart_idx == clint_hart_idx_width_gp'(h)))
        rdata = {{(clint_dword_width_gp-1){1'b0}}, msoftint_r[h]};
    end
  end

  // Free-running counter; a software store overrides a coincident increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_r <= '0;
      mtime_r <= '0;
    end else begin
      presc_r <= tick ? '0 : presc_r + presc_width_lp'(1);
      if (wr_mtime)  mtime_r <= req.data;
      else if (tick) mtime_r <= mtime_r + clint_dword_width_gp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int h = 0; h < num_core_p; h++) mtimecmp_r[h] <= '1;
      msoftint_r <= '0;
    end else begin
      for (int h = 0; h < num_core_p; h++) begin
        if (accept && req.we && is_mtimecmp && (hart_idx == clint_hart_idx_width_gp'(h)))
          mtimecmp_r[h] <= req.data;
        if (accept && req.we && is_msoftint && (hart_idx == clint_hart_idx_width_gp'(h)))
          msoftint_r[h] <= req.data[0];
      end
    end
  end

  // Interrupt levels trail their source registers by one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_irq_r <= '0;
      soft_irq_r  <= '0;
    end else begin
      for (int h = 0; h < num_core_p; h++) timer_irq_r[h] <= (mtime_r >= mtimecmp_r[h]);
      soft_irq_r <= msoftint_r;
    end
  end

  // Request/response handshake; response payload frozen while waiting for resp_ready_i.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_clint_idle;
      resp_r  <= '0;
    end else begin
      case (state_r)
        e_clint_idle: begin
          if (req_v_i) begin
            state_r     <= e_clint_resp;
            resp_r.err  <= dec_err;
            resp_r.data <= (dec_err | req.we) ? '0 : rdata;
          end
        end
        e_clint_resp: begin
          if (resp_ready_i) state_r <= e_clint_idle;
        end
        default: state_r <= e_clint_idle;
      endcase
    end
  end

  assign req_ready_o = (state_r == e_clint_idle);
  assign resp_v_o    = (state_r == e_clint_resp);
  assign resp_data_o = dword_width_p'(resp_r.data);
  assign resp_err_o  = resp_r.err;
  assign timer_irq_o = timer_irq_r;
  assign soft_irq_o  = soft_irq_r;

endmodule

// File: tb/tb_bp_be_clint_responder.sv
// Directed bench for the CLINT responder: 6 harts, mtime advancing every 3 clocks.
// Edge numbers in comments count posedges since reset release (first edge = 1).
module tb_bp_be_clint_responder;

  localparam logic [38:0] a_mtime = 39'h6f_ffff_0000;
  localparam logic [38:0] a_cmp1  = 39'h6f_ffff_0108;
  localparam logic [38:0] a_cmp2  = 39'h6f_ffff_0110;
  localparam logic [38:0] a_soft0 = 39'h6f_ffff_0200;
  localparam logic [38:0] a_soft5 = 39'h6f_ffff_0228;
  localparam logic [63:0] all_ones = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i;
  logic        reset_i;
  logic        req_v_i;
  logic        req_ready_o;
  logic [38:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_data_i;
  logic        resp_v_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic [5:0]  timer_irq_o;
  logic [5:0]  soft_irq_o;

  int          n_checks;
  int          n_errors;
  logic [5:0]  t_irq;

  bp_be_clint_responder #(
    .num_core_p    (6),
    .paddr_width_p (39),
    .dword_width_p (64),
    .timer_div_p   (3)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_v_i      (req_v_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_data_i   (req_data_i),
    .resp_v_o     (resp_v_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .timer_irq_o  (timer_irq_o),
    .soft_irq_o   (soft_irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request with resp_ready_i high: acceptance edge, then response edge.
  task automatic issue(input logic [38:0] addr, input logic we, input logic [1:0] size,
                       input logic [63:0] data, input string tag,
                       input logic exp_err, input logic [63:0] exp_data);
    req_v_i    = 1'b1;
    req_addr_i = addr;
    req_we_i   = we;
    req_size_i = size;
    req_data_i = data;
    @(posedge clk_i); #1;
    req_v_i = 1'b0;
    @(negedge clk_i);
    check({tag, " resp_v"}, 64'(resp_v_o), 64'd1);
    check({tag, " ready"}, 64'(req_ready_o), 64'd0);
    check({tag, " err"}, 64'(resp_err_o), 64'(exp_err));
    check({tag, " data"}, resp_data_o, exp_data);
    t_irq = timer_irq_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    t_irq        = '0;
    reset_i      = 1'b1;
    req_v_i      = 1'b0;
    req_addr_i   = '0;
    req_we_i     = 1'b0;
    req_size_i   = 2'b11;
    req_data_i   = '0;
    resp_ready_i = 1'b1;

    #12;
    check("rst resp_v", 64'(resp_v_o), 64'd0);
    check("rst ready", 64'(req_ready_o), 64'd1);
    check("rst data", resp_data_o, 64'd0);
    check("rst err", 64'(resp_err_o), 64'd0);
    check("rst tirq", 64'(timer_irq_o), 64'd0);
    check("rst sirq", 64'(soft_irq_o), 64'd0);
    #10 reset_i = 1'b0;

    // mtime after edge 10 is floor(10/3) = 3
    repeat (10) @(posedge clk_i); #1;
    check("idle tirq", 64'(timer_irq_o), 64'd0);
    check("idle sirq", 64'(soft_irq_o), 64'd0);
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime idle", 1'b0, 64'd3);        // 11

    issue(a_soft5, 1'b1, 2'b11, all_ones, "st soft5", 1'b0, 64'd0);          // 13
    check("soft5 set", 64'(soft_irq_o), 64'h20);
    issue(a_soft5, 1'b0, 2'b11, 64'd0, "ld soft5", 1'b0, 64'd1);             // 15
    issue(a_soft5, 1'b1, 2'b11, 64'd0, "clr soft5", 1'b0, 64'd0);            // 17
    check("soft5 clr", 64'(soft_irq_o), 64'd0);

    issue(39'h6f_ffff_0300, 1'b0, 2'b11, 64'd0, "unmapped", 1'b1, 64'd0);    // 19
    issue(39'h6f_ffff_0104, 1'b0, 2'b11, 64'd0, "misaligned", 1'b1, 64'd0);  // 21
    issue(a_cmp2, 1'b1, 2'b10, 64'd5, "bad size", 1'b1, 64'd0);              // 23
    issue(a_cmp2, 1'b0, 2'b11, 64'd0, "cmp2 kept", 1'b0, all_ones);          // 25
    issue(39'h6f_ffff_0130, 1'b0, 2'b11, 64'd0, "cmp6 unmapped", 1'b1, 64'd0); // 27
    issue(39'h6f_ffff_0230, 1'b1, 2'b11, 64'd1, "st soft6", 1'b1, 64'd0);    // 29
    check("soft6 none", 64'(soft_irq_o), 64'd0);
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime 30", 1'b0, 64'd10);         // 31

    // Backpressure: accepted at 33 with mtime 10, held through edge 38
    resp_ready_i = 1'b0;
    req_v_i      = 1'b1;
    req_addr_i   = a_mtime;
    req_we_i     = 1'b0;
    req_size_i   = 2'b11;
    @(posedge clk_i); #1;
    req_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold resp_v", 64'(resp_v_o), 64'd1);
      check("hold data", resp_data_o, 64'd10);
      check("hold ready", 64'(req_ready_o), 64'd0);
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    req_v_i      = 1'b1;
    @(posedge clk_i); #1;                                                     // 39
    check("drain resp_v", 64'(resp_v_o), 64'd0);
    check("drain ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;                                                     // 40
    req_v_i = 1'b0;
    check("next resp_v", 64'(resp_v_o), 64'd1);
    check("next data", resp_data_o, 64'd13);
    @(posedge clk_i); #1;                                                     // 41

    // Store at 42 coincides with an increment; mtime then steps at 45, 48
    issue(a_mtime, 1'b1, 2'b11, 64'd100, "st mtime 100", 1'b0, 64'd0);       // 42
    issue(a_cmp2, 1'b1, 2'b11, 64'd102, "st cmp2", 1'b0, 64'd0);             // 44
    check("tirq before", 64'(timer_irq_o), 64'd0);
    repeat (3) @(posedge clk_i); #1;                                          // 48
    check("tirq at equal", 64'(timer_irq_o), 64'd0);
    @(posedge clk_i); #1;                                                     // 49
    check("tirq rise", 64'(timer_irq_o), 64'h04);
    issue(a_cmp2, 1'b1, 2'b11, all_ones, "st cmp2 max", 1'b0, 64'd0);        // 50
    check("tirq hold", 64'(t_irq), 64'h04);
    check("tirq drop", 64'(timer_irq_o), 64'd0);

    // Wrap: store at 54 (increment edge), steps at 57 and 60
    repeat (2) @(posedge clk_i); #1;                                          // 53
    issue(a_mtime, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, "st mtime wrap", 1'b0, 64'd0); // 54
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime fe", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);   // 56
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime ff", 1'b0, all_ones);       // 58
    check("tirq all max", 64'(t_irq), 64'h3f);
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime pre wrap", 1'b0, all_ones); // 60
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "ld mtime wrapped", 1'b0, 64'd0);     // 62
    check("tirq after wrap", 64'(timer_irq_o), 64'd0);

    // Load up state that reset must clear
    issue(a_cmp1, 1'b1, 2'b11, 64'd0, "st cmp1 zero", 1'b0, 64'd0);          // 64
    issue(a_soft0, 1'b1, 2'b11, 64'd1, "st soft0", 1'b0, 64'd0);             // 66
    check("tirq cmp1", 64'(timer_irq_o), 64'h02);
    check("sirq soft0", 64'(soft_irq_o), 64'h01);

    // Reset while the response (mtime 2) is pending
    req_v_i    = 1'b1;
    req_addr_i = a_mtime;
    req_we_i   = 1'b0;
    req_size_i = 2'b11;
    @(posedge clk_i); #1;                                                     // 68
    req_v_i = 1'b0;
    check("midresp resp_v", 64'(resp_v_o), 64'd1);
    check("midresp data", resp_data_o, 64'd2);
    #2 reset_i = 1'b1;
    #1;
    check("async resp_v", 64'(resp_v_o), 64'd0);
    check("async ready", 64'(req_ready_o), 64'd1);
    check("async data", resp_data_o, 64'd0);
    check("async err", 64'(resp_err_o), 64'd0);
    check("async tirq", 64'(timer_irq_o), 64'd0);
    check("async sirq", 64'(soft_irq_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #2 reset_i = 1'b0;

    repeat (4) @(posedge clk_i); #1;
    check("post rst resp_v", 64'(resp_v_o), 64'd0);
    check("post rst tirq", 64'(timer_irq_o), 64'd0);
    check("post rst sirq", 64'(soft_irq_o), 64'd0);
    issue(a_mtime, 1'b0, 2'b11, 64'd0, "post rst mtime", 1'b0, 64'd1);       // 5
    issue(a_soft0, 1'b0, 2'b11, 64'd0, "post rst soft0", 1'b0, 64'd0);       // 7
    issue(a_cmp1, 1'b0, 2'b11, 64'd0, "post rst cmp1", 1'b0, all_ones);      // 9

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
